// File: rtl/icebreaker_pkg.sv
// Shared types for the iCEBreaker memory arbiter: FSM states, grant ids and
// the memory-window membership helper.
package icebreaker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK_I = 2'd1,
    ACK_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_INSTR = 1'b0,
    GNT_DATA  = 1'b1
  } gnt_id_e;

  localparam int unsigned MEM_BYTES_DEFAULT = 131072;

  // An address is inside the window when every bit above the window size
  // matches the base; the base is assumed aligned to the window size.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned bytes);
    logic [31:0] hi_mask;
    hi_mask = ~(bytes - 32'd1);
    return ((addr ^ base) & hi_mask) == 32'd0;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a per-requester mask. On a conflict
// the requester that was not granted last wins; bit 0 is instr, bit 1 is data.
module rr_arbiter2
  import icebreaker_pkg::*;
(
  input  logic       clk_i,
  input  logic       rstz_i,
  input  logic [1:0] req_i,
  input  logic [1:0] mask_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  gnt_id_e    last_grant_q, last_grant_d;
  logic [1:0] eligible;

  assign eligible = req_i & ~mask_i;

  always_comb begin
    gnt_o = 2'b00;
    case (eligible)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_grant_q == GNT_INSTR) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (advance_i && (gnt_o != 2'b00)) begin
      last_grant_d = gnt_o[1] ? GNT_DATA : GNT_INSTR;
    end
  end

  always_ff @(posedge clk_i or negedge rstz_i) begin
    if (!rstz_i) begin
      last_grant_q <= GNT_INSTR;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/icebreaker_mem_arbiter.sv
// Shares the single-port SPRAM between the fetch and data ports: one issue per
// cycle, ack one cycle later, out-of-window accesses acked with zero data.
module icebreaker_mem_arbiter
  import icebreaker_pkg::*;
#(
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] instr_addr,
  input  logic        instr_req,
  output logic [31:0] instr_data,
  output logic        instr_ack,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_mask,
  input  logic        data_wr_en,
  input  logic        data_req,
  output logic [31:0] data_rd_data,
  output logic        data_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wr_mask,
  output logic        mem_en,
  output logic        mem_wr_en,
  input  logic [31:0] mem_rdata
);

  arb_state_e state_q, state_d;
  logic       oor_q, oor_d;
  logic [1:0] gnt;
  logic [1:0] port_mask;
  logic       issue;
  logic       in_range;

  // The port being acked still holds its req, so keep it out of arbitration.
  assign port_mask = {state_q == ACK_D, state_q == ACK_I};

  rr_arbiter2 u_rr (
    .clk_i     (clk),
    .rstz_i    (rstz),
    .req_i     ({data_req, instr_req}),
    .mask_i    (port_mask),
    .advance_i (1'b1),
    .gnt_o     (gnt)
  );

  assign issue       = |gnt;
  assign mem_addr    = gnt[0] ? instr_addr : data_addr;
  assign mem_wdata   = data_wr_data;
  assign mem_wr_mask = gnt[0] ? 4'b0000 : data_mask;
  assign in_range    = in_window(mem_addr, MEM_BASE, MEM_BYTES);
  assign mem_en      = issue & in_range;
  assign mem_wr_en   = mem_en & gnt[1] & data_wr_en;

  always_comb begin
    state_d = IDLE;
    oor_d   = 1'b0;
    if (gnt[1]) begin
      state_d = ACK_D;
      oor_d   = ~in_range;
    end else if (gnt[0]) begin
      state_d = ACK_I;
      oor_d   = ~in_range;
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q <= IDLE;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      oor_q   <= oor_d;
    end
  end

  assign instr_ack    = (state_q == ACK_I);
  assign data_ack     = (state_q == ACK_D);
  assign instr_data   = oor_q ? 32'h0 : mem_rdata;
  assign data_rd_data = oor_q ? 32'h0 : mem_rdata;

  a_single_ack : assert property (@(posedge clk) disable iff (!rstz)
    !(instr_ack && data_ack));
  a_write_needs_en : assert property (@(posedge clk) disable iff (!rstz)
    mem_wr_en |-> mem_en);
  a_state_legal : assert property (@(posedge clk) disable iff (!rstz)
    state_q inside {IDLE, ACK_I, ACK_D});

endmodule

// File: tb/tb_icebreaker_mem_arbiter.sv
// Self-checking bench for icebreaker_mem_arbiter: directed scenarios plus
// randomized two-port traffic checked against a shadow memory model.
module tb_icebreaker_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstz;
  logic [31:0] instr_addr, instr_data;
  logic        instr_req, instr_ack;
  logic [31:0] data_addr, data_wr_data, data_rd_data;
  logic [3:0]  data_mask;
  logic        data_wr_en, data_req, data_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wr_mask;
  logic        mem_en, mem_wr_en;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  icebreaker_mem_arbiter dut (
    .clk          (clk),
    .rstz         (rstz),
    .instr_addr   (instr_addr),
    .instr_req    (instr_req),
    .instr_data   (instr_data),
    .instr_ack    (instr_ack),
    .data_addr    (data_addr),
    .data_wr_data (data_wr_data),
    .data_mask    (data_mask),
    .data_wr_en   (data_wr_en),
    .data_req     (data_req),
    .data_rd_data (data_rd_data),
    .data_ack     (data_ack),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wr_mask  (mem_wr_mask),
    .mem_en       (mem_en),
    .mem_wr_en    (mem_wr_en),
    .mem_rdata    (mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0001 ^ (32'(i) * 32'h9E37_79B9);
  endfunction

  // Default window: base 0, 128KB.
  function automatic bit in_mem(input logic [31:0] a);
    return a[31:17] == 15'd0;
  endfunction

  // SPRAM stand-in: registered read (old data on a write cycle), byte-masked write.
  logic [31:0] mem [0:32767];
  bit          written [0:32767];
  logic [31:0] mcur;
  logic [14:0] midx;
  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      midx = mem_addr[16:2];
      mcur = written[midx] ? mem[midx] : init_word(int'(midx));
      mem_rdata <= mcur;
      if (mem_wr_en === 1'b1) begin
        for (int b = 0; b < 4; b++) if (mem_wr_mask[b]) mcur[b*8 +: 8] = mem_wdata[b*8 +: 8];
        mem[midx]     <= mcur;
        written[midx] <= 1'b1;
      end
    end
  end

  logic [31:0] shadow [0:32767];

  bit          pend_i = 0, pend_d = 0, acked_i = 0, acked_d = 0;
  logic [31:0] a_i = 0, a_d = 0, wd_d = 0;
  logic [3:0]  m_d = 0;
  bit          we_d = 0;
  int          st_i = 0, st_d = 0;

  task automatic drive_idle();
    instr_req = 0; instr_addr = 0;
    data_req = 0; data_addr = 0; data_wr_en = 0; data_wr_data = 0; data_mask = 0;
  endtask

  function automatic logic [31:0] rand_addr(input bit oor_ok);
    int unsigned r;
    r = $urandom_range(0, 9);
    if (oor_ok && r == 0) return ($urandom() & 32'hFFFF_FFFC) | 32'h0002_0000;
    if (r == 1) return 32'h0001_FFFC;
    return {23'd0, 7'($urandom_range(0, 95)), 2'b00};
  endfunction

  task automatic do_access(input bit is_data, input logic [31:0] addr, input bit we,
                           input logic [31:0] wd, input logic [3:0] mk,
                           output logic iss_en, output logic iss_wr, output logic [31:0] iss_addr,
                           output logic [3:0] iss_mask, output logic ack, output logic [31:0] rd);
    @(posedge clk); #1;
    if (is_data) begin
      data_req = 1; data_addr = addr; data_wr_en = we; data_wr_data = wd; data_mask = mk;
    end else begin
      instr_req = 1; instr_addr = addr;
    end
    @(negedge clk);
    iss_en = mem_en; iss_wr = mem_wr_en; iss_addr = mem_addr; iss_mask = mem_wr_mask;
    @(posedge clk); #1;
    @(negedge clk);
    ack = is_data ? data_ack : instr_ack;
    rd  = is_data ? data_rd_data : instr_data;
    @(posedge clk); #1;
    drive_idle();
  endtask

  // Randomized traffic; every ack is checked against the shadow memory in ack (= issue) order.
  task automatic run_traffic(input int n, input int pi, input int pd, input bit oor_ok,
                             input bit st_ok, output int n_ack, output int alt_err);
    int last_owner;
    int lat;
    logic [31:0] exp;
    n_ack = 0; alt_err = 0; last_owner = -1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (acked_i) begin pend_i = 0; acked_i = 0; end
      if (acked_d) begin pend_d = 0; acked_d = 0; end
      if (!pend_i && int'($urandom_range(0, 99)) < pi) begin
        pend_i = 1; a_i = rand_addr(oor_ok); st_i = cyc;
      end
      if (!pend_d && int'($urandom_range(0, 99)) < pd) begin
        pend_d = 1; a_d = rand_addr(oor_ok); we_d = st_ok && ($urandom_range(0, 1) == 1);
        wd_d = $urandom(); m_d = 4'($urandom_range(1, 15)); st_d = cyc;
      end
      instr_req = pend_i; instr_addr = a_i;
      data_req = pend_d; data_addr = a_d; data_wr_en = we_d; data_wr_data = wd_d; data_mask = m_d;
      @(negedge clk);
      total++;
      if ((instr_ack & data_ack) !== 1'b0) begin
        bad++; $display("[TB] FAIL dual_ack: instr_ack=%b data_ack=%b, required at most one", instr_ack, data_ack);
      end
      if (instr_ack === 1'b1) begin
        n_ack++;
        if (last_owner == 0) alt_err++;
        last_owner = 0;
        total++;
        if (!(pend_i && !acked_i)) begin
          bad++; $display("[TB] FAIL spurious_instr_ack at cycle %0d: ack=1, required 0", cyc);
        end else begin
          lat = cyc - st_i;
          total++;
          if (lat < 1 || lat > 2) begin
            bad++; $display("[TB] FAIL instr_latency: got %0d cycles, required 1..2", lat);
          end
          exp = in_mem(a_i) ? shadow[a_i[16:2]] : 32'h0;
          total++;
          if (instr_data !== exp) begin
            bad++; $display("[TB] FAIL instr_data addr=%h: got %h, required %h", a_i, instr_data, exp);
          end
          acked_i = 1;
        end
      end else if (pend_i && !acked_i && (cyc - st_i) >= 2) begin
        total++; bad++;
        $display("[TB] FAIL instr_timeout addr=%h: no ack after %0d cycles, required <=2", a_i, cyc - st_i);
        pend_i = 0;
      end
      if (data_ack === 1'b1) begin
        n_ack++;
        if (last_owner == 1) alt_err++;
        last_owner = 1;
        total++;
        if (!(pend_d && !acked_d)) begin
          bad++; $display("[TB] FAIL spurious_data_ack at cycle %0d: ack=1, required 0", cyc);
        end else begin
          lat = cyc - st_d;
          total++;
          if (lat < 1 || lat > 2) begin
            bad++; $display("[TB] FAIL data_latency: got %0d cycles, required 1..2", lat);
          end
          if (we_d) begin
            if (in_mem(a_d))
              for (int b = 0; b < 4; b++) if (m_d[b]) shadow[a_d[16:2]][b*8 +: 8] = wd_d[b*8 +: 8];
          end else begin
            exp = in_mem(a_d) ? shadow[a_d[16:2]] : 32'h0;
            total++;
            if (data_rd_data !== exp) begin
              bad++; $display("[TB] FAIL data_rd_data addr=%h: got %h, required %h", a_d, data_rd_data, exp);
            end
          end
          acked_d = 1;
        end
      end else if (pend_d && !acked_d && (cyc - st_d) >= 2) begin
        total++; bad++;
        $display("[TB] FAIL data_timeout addr=%h: no ack after %0d cycles, required <=2", a_d, cyc - st_d);
        pend_d = 0;
      end
      if (mem_en === 1'b1) begin
        total++;
        if (!in_mem(mem_addr)) begin
          bad++; $display("[TB] FAIL en_out_of_window: mem_en=1 at addr %h, required 0", mem_addr);
        end
      end
      if (mem_wr_en === 1'b1) begin
        total++;
        if (mem_en !== 1'b1) begin
          bad++; $display("[TB] FAIL wr_without_en: mem_en=%b, required 1", mem_en);
        end
      end
    end
  endtask

  task automatic end_traffic();
    int na, ae;
    run_traffic(4, 0, 0, 0, 0, na, ae);
    @(posedge clk); #1;
    pend_i = 0; pend_d = 0; acked_i = 0; acked_d = 0;
    drive_idle();
  endtask

  task automatic test_reset();
    rstz = 0;
    drive_idle();
    repeat (2) @(negedge clk);
    instr_req = 1; data_req = 1;
    @(negedge clk); #1;
    total++;
    if (instr_ack !== 1'b0 || data_ack !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_acks: instr_ack=%b data_ack=%b, required 0/0", instr_ack, data_ack);
    end
    @(negedge clk); #1;
    total++;
    if (instr_ack !== 1'b0 || data_ack !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_acks_held: instr_ack=%b data_ack=%b, required 0/0", instr_ack, data_ack);
    end
    drive_idle();
    @(negedge clk);
    rstz = 1;
  endtask

  task automatic test_simultaneous();
    @(posedge clk); #1;
    instr_req = 1; instr_addr = 32'h0;
    data_req = 1; data_addr = 32'h40; data_wr_en = 0;
    @(negedge clk);
    total++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h40 || mem_wr_en !== 1'b0) begin
      bad++; $display("[TB] FAIL sim_first_issue: en=%b addr=%h wr=%b, required 1/00000040/0", mem_en, mem_addr, mem_wr_en);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (data_ack !== 1'b1 || instr_ack !== 1'b0 || data_rd_data !== shadow[16]) begin
      bad++; $display("[TB] FAIL sim_data_ack: ack=%b iack=%b data=%h, required 1/0/%h", data_ack, instr_ack, data_rd_data, shadow[16]);
    end
    total++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h0) begin
      bad++; $display("[TB] FAIL sim_second_issue: en=%b addr=%h, required 1/00000000", mem_en, mem_addr);
    end
    @(posedge clk); #1;
    data_req = 0;
    @(negedge clk);
    total++;
    if (instr_ack !== 1'b1 || data_ack !== 1'b0 || instr_data !== shadow[0] || mem_en !== 1'b0) begin
      bad++; $display("[TB] FAIL sim_instr_ack: iack=%b dack=%b data=%h en=%b, required 1/0/%h/0", instr_ack, data_ack, instr_data, mem_en, shadow[0]);
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic test_fetch_only();
    @(posedge clk); #1;
    instr_req = 1; instr_addr = 32'h100;
    @(negedge clk);
    total++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h100 || instr_ack !== 1'b0) begin
      bad++; $display("[TB] FAIL fetch_issue: en=%b addr=%h ack=%b, required 1/00000100/0", mem_en, mem_addr, instr_ack);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (instr_ack !== 1'b1 || instr_data !== shadow[64] || mem_en !== 1'b0) begin
      bad++; $display("[TB] FAIL fetch_ack: ack=%b data=%h en=%b, required 1/%h/0", instr_ack, instr_data, mem_en, shadow[64]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h100 || instr_ack !== 1'b0) begin
      bad++; $display("[TB] FAIL fetch_reissue: en=%b addr=%h ack=%b, required 1/00000100/0", mem_en, mem_addr, instr_ack);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (instr_ack !== 1'b1) begin
      bad++; $display("[TB] FAIL fetch_reack: ack=%b, required 1", instr_ack);
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    total++;
    if (instr_ack !== 1'b0 || mem_en !== 1'b0) begin
      bad++; $display("[TB] FAIL fetch_idle: ack=%b en=%b, required 0/0", instr_ack, mem_en);
    end
  endtask

  task automatic test_round_robin();
    logic en, wr, ack;
    logic [31:0] ad, rd;
    logic [3:0] mk;
    do_access(1, 32'h44, 0, 32'h0, 4'h0, en, wr, ad, mk, ack, rd);
    total++;
    if (ack !== 1'b1 || rd !== shadow[17]) begin
      bad++; $display("[TB] FAIL rr_data_load: ack=%b data=%h, required 1/%h", ack, rd, shadow[17]);
    end
    @(posedge clk); #1;
    instr_req = 1; instr_addr = 32'h8;
    data_req = 1; data_addr = 32'hC; data_wr_en = 0;
    @(negedge clk);
    total++;
    if (mem_addr !== 32'h8 || mem_en !== 1'b1) begin
      bad++; $display("[TB] FAIL rr_instr_wins: addr=%h en=%b, required 00000008/1", mem_addr, mem_en);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (instr_ack !== 1'b1 || instr_data !== shadow[2] || mem_addr !== 32'hC || mem_en !== 1'b1) begin
      bad++; $display("[TB] FAIL rr_followup: iack=%b data=%h addr=%h en=%b, required 1/%h/0000000c/1", instr_ack, instr_data, mem_addr, mem_en, shadow[2]);
    end
    @(posedge clk); #1;
    instr_req = 0;
    @(negedge clk);
    total++;
    if (data_ack !== 1'b1 || data_rd_data !== shadow[3]) begin
      bad++; $display("[TB] FAIL rr_data_ack: ack=%b data=%h, required 1/%h", data_ack, data_rd_data, shadow[3]);
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic test_masked_store();
    logic en, wr, ack;
    logic [31:0] ad, rd, old, exp;
    logic [3:0] mk;
    old = shadow[32];
    exp = {old[31:16], 16'hCCDD};
    do_access(1, 32'h80, 1, 32'hAABB_CCDD, 4'b0011, en, wr, ad, mk, ack, rd);
    total++;
    if (en !== 1'b1 || wr !== 1'b1 || ad !== 32'h80 || mk !== 4'b0011 || ack !== 1'b1) begin
      bad++; $display("[TB] FAIL store_issue: en=%b wr=%b addr=%h mask=%b ack=%b, required 1/1/00000080/0011/1", en, wr, ad, mk, ack);
    end
    shadow[32] = exp;
    do_access(1, 32'h80, 0, 32'h0, 4'h0, en, wr, ad, mk, ack, rd);
    total++;
    if (wr !== 1'b0 || ack !== 1'b1 || rd !== exp) begin
      bad++; $display("[TB] FAIL store_readback: wr=%b ack=%b data=%h, required 0/1/%h", wr, ack, rd, exp);
    end
    do_access(0, 32'h80, 0, 32'h0, 4'h0, en, wr, ad, mk, ack, rd);
    total++;
    if (ack !== 1'b1 || rd !== exp) begin
      bad++; $display("[TB] FAIL store_fetch_readback: ack=%b data=%h, required 1/%h", ack, rd, exp);
    end
  endtask

  task automatic test_out_of_range();
    logic en, wr, ack;
    logic [31:0] ad, rd;
    logic [3:0] mk;
    do_access(1, 32'h0002_0000, 1, 32'h1234_5678, 4'hF, en, wr, ad, mk, ack, rd);
    total++;
    if (en !== 1'b0 || wr !== 1'b0 || ack !== 1'b1) begin
      bad++; $display("[TB] FAIL oor_store: en=%b wr=%b ack=%b, required 0/0/1", en, wr, ack);
    end
    do_access(1, 32'h0, 0, 32'h0, 4'h0, en, wr, ad, mk, ack, rd);
    total++;
    if (ack !== 1'b1 || rd !== shadow[0]) begin
      bad++; $display("[TB] FAIL oor_no_alias: ack=%b data=%h, required 1/%h", ack, rd, shadow[0]);
    end
    do_access(1, 32'h0002_0000, 0, 32'h0, 4'h0, en, wr, ad, mk, ack, rd);
    total++;
    if (en !== 1'b0 || ack !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("[TB] FAIL oor_load: en=%b ack=%b data=%h, required 0/1/00000000", en, ack, rd);
    end
    do_access(0, 32'hFFFF_FFF0, 0, 32'h0, 4'h0, en, wr, ad, mk, ack, rd);
    total++;
    if (en !== 1'b0 || ack !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("[TB] FAIL oor_fetch: en=%b ack=%b data=%h, required 0/1/00000000", en, ack, rd);
    end
    do_access(0, 32'h0001_FFFC, 0, 32'h0, 4'h0, en, wr, ad, mk, ack, rd);
    total++;
    if (en !== 1'b1 || ack !== 1'b1 || rd !== shadow[32767]) begin
      bad++; $display("[TB] FAIL last_word: en=%b ack=%b data=%h, required 1/1/%h", en, ack, rd, shadow[32767]);
    end
  endtask

  task automatic test_contention();
    int na, ae;
    run_traffic(20, 100, 100, 0, 0, na, ae);
    total++;
    if (ae != 0) begin
      bad++; $display("[TB] FAIL contention_alternate: %0d repeated owners, required 0", ae);
    end
    total++;
    if (na < 19 || na > 20) begin
      bad++; $display("[TB] FAIL contention_acks: got %0d acks, required 19..20", na);
    end
    end_traffic();
  endtask

  task automatic test_random();
    int na, ae;
    run_traffic(400, 45, 45, 1, 1, na, ae);
    end_traffic();
    total++;
    if (na < 100) begin
      bad++; $display("[TB] FAIL random_throughput: got %0d acks, required >=100", na);
    end
  endtask

  task automatic test_reset_mid_access();
    @(posedge clk); #1;
    data_req = 1; data_addr = 32'h48; data_wr_en = 0;
    @(negedge clk);
    @(posedge clk); #1;
    total++;
    if (data_ack !== 1'b1) begin
      bad++; $display("[TB] FAIL mid_reset_pre_ack: ack=%b, required 1", data_ack);
    end
    rstz = 0;
    #1;
    total++;
    if (data_ack !== 1'b0 || instr_ack !== 1'b0) begin
      bad++; $display("[TB] FAIL mid_reset_drop: dack=%b iack=%b, required 0/0", data_ack, instr_ack);
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    rstz = 1;
    @(posedge clk); #1;
    instr_req = 1; instr_addr = 32'h4;
    data_req = 1; data_addr = 32'h50; data_wr_en = 0;
    @(negedge clk);
    total++;
    if (mem_addr !== 32'h50 || data_ack !== 1'b0) begin
      bad++; $display("[TB] FAIL post_reset_data_first: addr=%h dack=%b, required 00000050/0", mem_addr, data_ack);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (data_ack !== 1'b1 || data_rd_data !== shadow[20]) begin
      bad++; $display("[TB] FAIL post_reset_data_ack: ack=%b data=%h, required 1/%h", data_ack, data_rd_data, shadow[20]);
    end
    @(posedge clk); #1;
    data_req = 0;
    @(negedge clk);
    total++;
    if (instr_ack !== 1'b1 || instr_data !== shadow[1]) begin
      bad++; $display("[TB] FAIL post_reset_instr_ack: ack=%b data=%h, required 1/%h", instr_ack, instr_data, shadow[1]);
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32768; i++) shadow[i] = init_word(i);
    $display("[TB] starting");
    test_reset();
    test_simultaneous();
    test_fetch_only();
    test_round_robin();
    test_masked_store();
    test_out_of_range();
    test_contention();
    test_random();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
